// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {
        PFX_IDLE,
        PFX_EXT,
        PFX_BRK,
        PFX_EXT_BRK
    } ps2_prefix_e;

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO of key events; head is presented combinationally.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  ps2_event_t               data_i,
    input  logic                     pop_i,
    output ps2_event_t               data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    ps2_event_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && valid_o;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin sync, 11-bit deframing with timeout, E0/F0 prefix
// folding into key events, and a show-ahead event FIFO with valid/ready.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    key_code,
    output logic                          key_break,
    output logic                          key_ext,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   prev_clk_q;
    logic [3:0]             bit_cnt_q;
    logic [9:0]             frame_q;
    logic [TO_W-1:0]        to_cnt_q;
    ps2_prefix_e            pfx_q;
    logic                   push_q;
    ps2_event_t             event_q;
    logic                   parity_err_q;
    logic                   frame_err_q;
    logic                   overflow_q;

    logic       clk_s;
    logic       data_s;
    logic       fall;
    logic [7:0] rx_byte;
    logic       fifo_full;
    logic       pop;
    ps2_event_t head;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign data_s  = data_sync_q[SYNC_STAGES-1];
    assign fall    = prev_clk_q && !clk_s;
    assign rx_byte = frame_q[8:1];
    assign pop     = key_valid && key_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            prev_clk_q   <= 1'b1;
            bit_cnt_q    <= '0;
            frame_q      <= '0;
            to_cnt_q     <= '0;
            pfx_q        <= PFX_IDLE;
            push_q       <= 1'b0;
            event_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            prev_clk_q   <= clk_s;
            push_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= push_q && fifo_full && !pop;

            if (fall) begin
                to_cnt_q <= '0;
                if (bit_cnt_q == 4'd10) begin
                    // frame_q holds start..parity LSB-first; data_s is the stop bit
                    bit_cnt_q <= '0;
                    if (frame_q[0] || !data_s) begin
                        frame_err_q <= 1'b1;
                        pfx_q       <= PFX_IDLE;
                    end else if (^frame_q[9:1] != 1'b1) begin
                        parity_err_q <= 1'b1;
                        pfx_q        <= PFX_IDLE;
                    end else if (rx_byte == PS2_EXT) begin
                        if (pfx_q == PFX_IDLE) pfx_q <= PFX_EXT;
                    end else if (rx_byte == PS2_BRK) begin
                        if (pfx_q == PFX_IDLE)     pfx_q <= PFX_BRK;
                        else if (pfx_q == PFX_EXT) pfx_q <= PFX_EXT_BRK;
                    end else begin
                        push_q       <= 1'b1;
                        event_q.ext  <= (pfx_q == PFX_EXT) || (pfx_q == PFX_EXT_BRK);
                        event_q.brk  <= (pfx_q == PFX_BRK) || (pfx_q == PFX_EXT_BRK);
                        event_q.code <= rx_byte;
                        pfx_q        <= PFX_IDLE;
                    end
                end else begin
                    frame_q   <= {data_s, frame_q[9:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (bit_cnt_q != '0) begin
                if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    frame_err_q <= 1'b1;
                    bit_cnt_q   <= '0;
                    to_cnt_q    <= '0;
                    pfx_q       <= PFX_IDLE;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_q),
        .data_i  (event_q),
        .pop_i   (pop),
        .data_o  (head),
        .valid_o (key_valid),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign key_code   = head.code;
    assign key_break  = head.brk;
    assign key_ext    = head.ext;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames in, events checked by a monitor.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO    = 512;
    localparam int unsigned HALF  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_ready = 1'b0;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       key_valid;
    logic [3:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    ps2_event_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int seen_par = 0, seen_frm = 0, seen_ovf = 0;
    int exp_par  = 0, exp_frm  = 0, exp_ovf  = 0;
    logic prev_par = 1'b0, prev_frm = 1'b0, prev_ovf = 1'b0;

    ps2_keyboard_rx #(
        .SYNC_STAGES    (3),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .key_break  (key_break),
        .key_ext    (key_ext),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        tick(30);
    endtask

    task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
        ps2_event_t e;
        e.ext = ext; e.brk = brk; e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0 && !key_valid) break;
            tick(1);
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_parity_err_count"}, seen_par, exp_par);
        check({tag, "_frame_err_count"},  seen_frm, exp_frm);
        check({tag, "_overflow_count"},   seen_ovf, exp_ovf);
    endtask

    // Monitor: pops the scoreboard on each accepted head, tracks one-cycle pulses.
    initial begin
        ps2_event_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (key_valid && key_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_event: got ext=%0b brk=%0b code=%02h expected none",
                                 key_ext, key_break, key_code);
                    end else begin
                        e = exp_q.pop_front();
                        check("event", {22'd0, key_ext, key_break, key_code}, {22'd0, e});
                    end
                end
                if (!key_valid) check("empty_fields_zero", {22'd0, key_ext, key_break, key_code}, 0);
                if (parity_err) begin seen_par++; check("parity_err_width", prev_par, 0); end
                if (frame_err)  begin seen_frm++; check("frame_err_width",  prev_frm, 0); end
                if (overflow)   begin seen_ovf++; check("overflow_width",   prev_ovf, 0); end
            end
            prev_par = parity_err;
            prev_frm = frame_err;
            prev_ovf = overflow;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        tick(5);
        check("reset_key_valid",  key_valid, 0);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_pulses",     {parity_err, frame_err, overflow}, 0);
        check("reset_key_fields", {key_ext, key_break, key_code}, 0);
        reset = 1'b0;
        tick(10);
        check_counts("idle_after_reset");

        key_ready = 1'b1;
        expect_ev(0, 0, 8'h1C); send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        expect_ev(0, 1, 8'h1C); send_frame(8'h1C, 0, 0);
        send_frame(8'hE0, 0, 0);
        expect_ev(1, 0, 8'h75); send_frame(8'h75, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        expect_ev(1, 1, 8'h75); send_frame(8'h75, 0, 0);
        wait_drained("basic_drain");

        exp_par++; send_frame(8'h1C, 1, 0);
        tick(5);
        check_counts("parity");
        send_frame(8'hF0, 0, 0);
        expect_ev(0, 1, 8'h1C); send_frame(8'h1C, 0, 0);
        wait_drained("after_parity_drain");
        send_frame(8'hF0, 0, 0);
        exp_par++; send_frame(8'h2A, 1, 0);
        expect_ev(0, 0, 8'h2B); send_frame(8'h2B, 0, 0);
        exp_frm++; send_frame(8'h1C, 0, 1);
        tick(5);
        check_counts("stop_bit");
        wait_drained("after_stop_drain");

        for (int i = 0; i < 6; i++) ps2_bit(1'b0);
        ps2_data = 1'b1;
        tick(TO + 20);
        exp_frm++;
        check_counts("timeout");
        expect_ev(0, 0, 8'h32); send_frame(8'h32, 0, 0);
        wait_drained("after_timeout_drain");

        key_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH) expect_ev(0, 0, 8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i), 0, 0);
        end
        exp_ovf++;
        check("fifo_count_full", fifo_count, DEPTH);
        check("key_valid_full",  key_valid, 1);
        check_counts("overflow");
        key_ready = 1'b1;
        wait_drained("overflow_drain");
        check("fifo_count_drained", fifo_count, 0);

        key_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_ev(0, 0, 8'h40 + 8'(i));
            send_frame(8'h40 + 8'(i), 0, 0);
        end
        check("fifo_count_three", fifo_count, 3);
        for (int i = 0; i < 6; i++) ps2_bit(1'b1);
        reset = 1'b1;
        #1;
        check("mid_reset_key_valid",  key_valid, 0);
        check("mid_reset_fifo_count", fifo_count, 0);
        exp_q.delete();
        ps2_data = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(10);
        key_ready = 1'b1;
        expect_ev(0, 0, 8'h1C); send_frame(8'h1C, 0, 0);
        wait_drained("after_reset_drain");

        tick(20);
        check_counts("final");
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver: synchronises the PS/2 clock/data lines, deframes 11-bit frames with full start/parity/stop checking and a mid-frame timeout, folds `E0`/`F0` prefix bytes into single key events, and buffers events in a show-ahead FIFO with a valid/ready handshake. It sits between the board PS/2 pins and the keyboard MMIO/device logic. It replaces the single-byte, single-register receiver: no lost bytes under back-pressure, explicit error reporting, decoded make/break/extended events.

## Interface
- `SYNC_STAGES`, 3: flops on `ps2_clk` and on `ps2_data`, both paths equal depth; minimum 2.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 4096: `clk` cycles without a PS/2 falling edge before a partial frame is aborted.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `key_code` output 8: scan code of FIFO head event.
- `key_break` output 1: head event is a release (`F0` seen).
- `key_ext` output 1: head event is extended (`E0` seen).
- `key_valid` output 1: FIFO non-empty; head fields are valid.
- `key_ready` input 1: consumer accepts head when `key_valid && key_ready`.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: entries held.
- `parity_err` output 1: one-cycle pulse, frame dropped on bad odd parity.
- `frame_err` output 1: one-cycle pulse, bad start bit, bad stop bit, or timeout.
- `overflow` output 1: one-cycle pulse, event dropped because FIFO full.

## Operation
- Both sync chains reset to all-ones (idle line high); no spurious edge after reset.
- `fall` = previous synced clk high and current synced clk low; data sampled from synced data in the same cycle.
- Deframer: bit counter 0..10; bits LSB-first: start(0), d0..d7, parity, stop(1). On `fall` with counter 10: frame checked, counter cleared. Start≠0 or stop≠1 → `frame_err`; else XOR(d,parity)≠1 → `parity_err`; else byte valid. Start error takes priority over parity.
- Timeout counter: cleared on every `fall`; counts while counter≠0; reaching `TIMEOUT_CYCLES-1` → `frame_err` pulse, bit counter cleared.
- Prefix FSM states: `IDLE`, `EXT` (E0 seen), `BRK` (F0 seen), `EXT_BRK` (E0 F0 seen). Valid byte `E0`: IDLE→EXT (other states: stay). Valid `F0`: IDLE→BRK, EXT→EXT_BRK. Any other valid byte: push event {ext,brk,code} per current state, →IDLE. Any parity/frame error: →IDLE, no push.
- FIFO: push on event when not full, or when full with a pop the same cycle; otherwise drop and pulse `overflow`. Pop on `key_valid && key_ready`. Pointers wrap modulo `FIFO_DEPTH`.
- Reset mid-frame: partial frame, prefix state and FIFO contents discarded.

## Timing
- All outputs 0 in reset; `key_*` fields 0 while empty.
- Byte decision registered: error pulse or FIFO push occurs 1 `clk` after the cycle `fall` is detected for bit 10.
- `key_valid` rises the cycle after the push; total pin-to-`key_valid` ≤ `SYNC_STAGES`+3 cycles.
- Pop is zero-latency show-ahead: next entry on `key_*` the cycle after the pop; `fifo_count` updates same edge.
- Error and overflow pulses are exactly one cycle; never simultaneous with a push from the same byte.

## Structure
- Package `ps2_pkg`: `ps2_event_t` {ext, brk, code[7:0]}, constants `PS2_EXT = 8'hE0`, `PS2_BRK = 8'hF0`, prefix-state enum.
- Sub-module `ps2_event_fifo` (parametrised show-ahead sync FIFO of `ps2_event_t`, count output); deframer, timeout and prefix FSM live in the top.

## Test plan
- Frames `1C`, `F0 1C` with `key_ready`=1 → events {0,0,1C} then {0,1,1C}; `F0` never visible alone.
- Frames `E0 75`, `E0 F0 75` → {1,0,75}, {1,1,75}.
- Frame `1C` with parity flipped → `parity_err` one cycle, no event; following `F0 1C` still → {0,1,1C}. Stop bit 0 → `frame_err`.
- 6 falling edges then idle `TIMEOUT_CYCLES` → `frame_err` pulse; next clean `32` frame → {0,0,32}.
- `key_ready`=0, send `FIFO_DEPTH`+1 codes → `fifo_count`=`FIFO_DEPTH`, one `overflow` pulse, drained order equals first `FIFO_DEPTH` codes.
- Assert `reset` after bit 5 of a frame and with 3 entries queued → `key_valid`=0, `fifo_count`=0 immediately; next full frame decodes correctly.
